// File: rtl/bram_arbiter_pkg.sv
// Shared types for the two-port block-RAM arbiter: request record, FSM states
// and the RAM word-address width.
package bram_arbiter_pkg;

    localparam int bram_depth = 10;

    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bram_req_t;

    localparam int bram_req_w = $bits(bram_req_t);

    typedef enum logic {
        IDLE,
        ACCESS
    } bram_arb_state_t;

    localparam logic grant_imem = 1'b0;
    localparam logic grant_dmem = 1'b1;

    // Fetches never write, so their strobes are forced to zero here once.
    function automatic bram_req_t make_req(
        input logic        instr,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [3:0]  wstrb
    );
        bram_req_t req;
        req.valid = 1'b1;
        req.instr = instr;
        req.addr  = addr;
        req.wdata = instr ? 32'h0 : wdata;
        req.wstrb = instr ? 4'h0 : wstrb;
        return req;
    endfunction

endpackage

// File: rtl/bram_pending.sv
// Single-entry request holding register. A load at the same edge as a clear
// wins, so a requester may re-issue in the cycle it is told the old one is done.
module bram_pending
    import bram_arbiter_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  clear,
    input  logic [bram_req_w-1:0] req_in,
    output logic [bram_req_w-1:0] entry
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entry <= '0;
        end else if (load) begin
            entry <= req_in;
        end else if (clear) begin
            entry <= '0;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin front end sharing one single-port block RAM between the fetch
// and load/store ports; one access in flight, responses steered to the grantee.
module bram_arbiter
    import bram_arbiter_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        bram_valid,
    output logic        bram_instr,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wdata,
    output logic [3:0]  bram_wstrb,
    input  logic [31:0] bram_rdata,
    input  logic        bram_ready
);

    bram_arb_state_t state;
    logic            last_grant;

    bram_req_t imem_pend;
    bram_req_t dmem_pend;
    bram_req_t imem_new;
    bram_req_t dmem_new;
    bram_req_t imem_eff;
    bram_req_t dmem_eff;
    bram_req_t issue_req;

    logic completing;
    logic imem_clear;
    logic dmem_clear;
    logic imem_load;
    logic dmem_load;
    logic pick_dmem;
    logic issue_now;

    assign completing = (state == ACCESS) && bram_ready;
    assign imem_clear = completing && (last_grant == grant_imem);
    assign dmem_clear = completing && (last_grant == grant_dmem);

    assign imem_ready = imem_clear;
    assign dmem_ready = dmem_clear;
    assign imem_rdata = bram_rdata;
    assign dmem_rdata = bram_rdata;

    // A request arriving while the port already holds one is dropped.
    assign imem_load = imem_valid && (!imem_pend.valid || imem_clear);
    assign dmem_load = dmem_valid && (!dmem_pend.valid || dmem_clear);

    assign imem_new = make_req(1'b1, imem_addr, 32'h0, 4'h0);
    assign dmem_new = make_req(1'b0, dmem_addr, dmem_wdata, dmem_wstrb);

    bram_pending u_imem_pending (
        .clock  (clock),
        .reset  (reset),
        .load   (imem_load),
        .clear  (imem_clear),
        .req_in (imem_new),
        .entry  (imem_pend)
    );

    bram_pending u_dmem_pending (
        .clock  (clock),
        .reset  (reset),
        .load   (dmem_load),
        .clear  (dmem_clear),
        .req_in (dmem_new),
        .entry  (dmem_pend)
    );

    // Candidates bypass the holding register so a fresh request reaches the
    // RAM one cycle after its valid; the entry itself stays set until ready.
    always_comb begin
        imem_eff = '0;
        if (imem_pend.valid && !imem_clear) begin
            imem_eff = imem_pend;
        end else if (imem_load) begin
            imem_eff = imem_new;
        end

        dmem_eff = '0;
        if (dmem_pend.valid && !dmem_clear) begin
            dmem_eff = dmem_pend;
        end else if (dmem_load) begin
            dmem_eff = dmem_new;
        end

        pick_dmem = dmem_eff.valid && (!imem_eff.valid || (last_grant == grant_imem));
        issue_req = pick_dmem ? dmem_eff : imem_eff;
        issue_now = ((state == IDLE) || completing) && issue_req.valid;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= grant_imem;
            bram_valid <= 1'b0;
            bram_instr <= 1'b0;
            bram_addr  <= 32'h0;
            bram_wdata <= 32'h0;
            bram_wstrb <= 4'h0;
        end else begin
            bram_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue_now) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bram_ready && !issue_now) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (issue_now) begin
                bram_valid <= 1'b1;
                bram_instr <= issue_req.instr;
                bram_addr  <= issue_req.addr;
                bram_wdata <= issue_req.wdata;
                bram_wstrb <= issue_req.wstrb;
                last_grant <= pick_dmem;
            end
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter with a behavioural one-cycle block RAM.
module tb_bram_arbiter;
    import bram_arbiter_pkg::*;

    localparam int ram_words = 1 << bram_depth;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_addr = 32'h0;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_valid = 1'b0;
    logic [31:0] dmem_addr = 32'h0;
    logic [31:0] dmem_wdata = 32'h0;
    logic [3:0]  dmem_wstrb = 4'h0;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        bram_valid;
    logic        bram_instr;
    logic [31:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [3:0]  bram_wstrb;
    logic [31:0] bram_rdata = 32'h0;
    logic        bram_ready = 1'b0;

    bram_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .imem_valid (imem_valid),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .dmem_valid (dmem_valid),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .bram_valid (bram_valid),
        .bram_instr (bram_instr),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_wstrb (bram_wstrb),
        .bram_rdata (bram_rdata),
        .bram_ready (bram_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          check_data;
        logic [31:0] data;
        int          ready_cycle;
    } exp_t;

    typedef struct {
        int         cyc;
        logic       instr;
        logic [3:0] wstrb;
    } grant_t;

    exp_t        imem_q[$];
    exp_t        dmem_q[$];
    grant_t      bram_log[$];
    logic [31:0] ram_mem [ram_words];
    logic [31:0] ref_mem [ram_words];
    int          cycle = 0;
    int          compared = 0;
    int          mismatched = 0;
    bit          imem_busy;
    bit          dmem_busy;

    function automatic int word_idx(input logic [31:0] a);
        return int'(a[bram_depth+1:2]);
    endfunction

    // Behavioural RAM: registered read, byte-strobed write, ready one cycle
    // after each request. It deliberately ignores the arbiter reset.
    always @(posedge clock) begin
        bram_ready <= bram_valid;
        if (bram_valid) begin
            bram_rdata <= ram_mem[word_idx(bram_addr)];
            for (int b = 0; b < 4; b++) begin
                if (bram_wstrb[b]) begin
                    ram_mem[word_idx(bram_addr)][8*b +: 8] <= bram_wdata[8*b +: 8];
                end
            end
        end
    end

    always @(posedge clock) begin
        cycle <= cycle + 1;
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            imem_busy <= 1'b0;
            dmem_busy <= 1'b0;
        end else begin
            if (imem_valid) begin
                assert (!imem_busy || imem_ready) else $error("[TB] imem protocol violation");
            end
            if (dmem_valid) begin
                assert (!dmem_busy || dmem_ready) else $error("[TB] dmem protocol violation");
            end
            imem_busy <= imem_valid || (imem_busy && !imem_ready);
            dmem_busy <= dmem_valid || (dmem_busy && !dmem_ready);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            if (bram_valid) begin
                bram_log.push_back('{cycle, bram_instr, bram_wstrb});
            end
            if (imem_ready) begin
                if (imem_q.size() == 0) begin
                    checkOutput("imem_spurious_ready", {31'b0, imem_ready}, 32'h0);
                end else begin
                    e = imem_q.pop_front();
                    if (e.check_data) checkOutput("imem_rdata", imem_rdata, e.data);
                    if (e.ready_cycle >= 0) checkOutput("imem_ready_cycle", 32'(cycle), 32'(e.ready_cycle));
                end
            end
            if (dmem_ready) begin
                if (dmem_q.size() == 0) begin
                    checkOutput("dmem_spurious_ready", {31'b0, dmem_ready}, 32'h0);
                end else begin
                    e = dmem_q.pop_front();
                    if (e.check_data) checkOutput("dmem_rdata", dmem_rdata, e.data);
                    if (e.ready_cycle >= 0) checkOutput("dmem_ready_cycle", 32'(cycle), 32'(e.ready_cycle));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives the requested ports for one cycle from the current cycle and
    // records the expected responses from the reference memory image.
    task automatic applyStimulus(
        input bit          do_i,
        input logic [31:0] i_addr,
        input int          i_lat,
        input bit          do_d,
        input logic [31:0] d_addr,
        input logic [31:0] d_wdata,
        input logic [3:0]  d_wstrb,
        input int          d_lat
    );
        exp_t e;
        if (do_i) begin
            imem_valid = 1'b1;
            imem_addr  = i_addr;
            e.check_data  = 1'b1;
            e.data        = ref_mem[word_idx(i_addr)];
            e.ready_cycle = (i_lat < 0) ? -1 : cycle + i_lat;
            imem_q.push_back(e);
        end
        if (do_d) begin
            dmem_valid = 1'b1;
            dmem_addr  = d_addr;
            dmem_wdata = d_wdata;
            dmem_wstrb = d_wstrb;
            e.check_data  = (d_wstrb == 4'h0);
            e.data        = ref_mem[word_idx(d_addr)];
            e.ready_cycle = (d_lat < 0) ? -1 : cycle + d_lat;
            dmem_q.push_back(e);
            for (int b = 0; b < 4; b++) begin
                if (d_wstrb[b]) ref_mem[word_idx(d_addr)][8*b +: 8] = d_wdata[8*b +: 8];
            end
        end
        tick();
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
    endtask

    task automatic waitDrain(input string tag, input int budget);
        for (int k = 0; k < budget && (imem_q.size() + dmem_q.size()) > 0; k++) begin
            tick();
        end
        checkOutput(tag, 32'(imem_q.size() + dmem_q.size()), 32'h0);
    endtask

    task automatic doReset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        imem_q.delete();
        dmem_q.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_bram_valid"}, {31'b0, bram_valid}, 32'h0);
        checkOutput({tag, "_bram_instr"}, {31'b0, bram_instr}, 32'h0);
        checkOutput({tag, "_bram_addr"},  bram_addr, 32'h0);
        checkOutput({tag, "_bram_wdata"}, bram_wdata, 32'h0);
        checkOutput({tag, "_bram_wstrb"}, {28'b0, bram_wstrb}, 32'h0);
        checkOutput({tag, "_imem_ready"}, {31'b0, imem_ready}, 32'h0);
        checkOutput({tag, "_dmem_ready"}, {31'b0, dmem_ready}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        int issued_i;
        int issued_d;
        bit do_i;
        bit do_d;

        for (int i = 0; i < ram_words; i++) begin
            ram_mem[i] = 32'hA5000000 ^ 32'(i * 32'h01010101);
        end
        ram_mem[0] = 32'hCAFEF00D;
        ram_mem[1] = 32'h12345678;
        ram_mem[2] = 32'hAAAAAAAA;
        ram_mem[4] = 32'hDEADBEEF;
        for (int i = 0; i < ram_words; i++) ref_mem[i] = ram_mem[i];

        tick();
        tick();
        checkQuiet("reset");
        reset = 1'b1;
        tick();

        $display("[TB] single fetch");
        bram_log.delete();
        c0 = cycle;
        applyStimulus(1'b1, 32'h10, 2, 1'b0, 32'h0, 32'h0, 4'h0, -1);
        waitDrain("fetch_drain", 20);
        checkOutput("fetch_grants", 32'(bram_log.size()), 32'd1);
        if (bram_log.size() > 0) begin
            checkOutput("fetch_bram_valid_cycle", 32'(bram_log[0].cyc), 32'(c0 + 1));
            checkOutput("fetch_bram_instr", {31'b0, bram_log[0].instr}, 32'd1);
            checkOutput("fetch_bram_wstrb", {28'b0, bram_log[0].wstrb}, 32'd0);
        end

        $display("[TB] simultaneous requests");
        doReset();
        bram_log.delete();
        c0 = cycle;
        applyStimulus(1'b1, 32'h0, 4, 1'b1, 32'h4, 32'h0, 4'h0, 2);
        waitDrain("simul_drain", 20);
        checkOutput("simul_grants", 32'(bram_log.size()), 32'd2);
        if (bram_log.size() > 1) begin
            checkOutput("simul_first_instr", {31'b0, bram_log[0].instr}, 32'd0);
            checkOutput("simul_second_instr", {31'b0, bram_log[1].instr}, 32'd1);
            checkOutput("simul_second_cycle", 32'(bram_log[1].cyc), 32'(c0 + 3));
        end

        $display("[TB] store then load");
        applyStimulus(1'b0, 32'h0, -1, 1'b1, 32'h8, 32'h11223344, 4'b0101, 2);
        waitDrain("store_drain", 20);
        applyStimulus(1'b0, 32'h0, -1, 1'b1, 32'h8, 32'h0, 4'h0, 2);
        waitDrain("load_drain", 20);

        $display("[TB] continuous contention");
        doReset();
        bram_log.delete();
        c0 = cycle;
        applyStimulus(1'b1, 32'h100, -1, 1'b1, 32'h200, 32'h0, 4'h0, -1);
        issued_i = 1;
        issued_d = 1;
        for (int k = 0; k < 60 && (issued_i < 4 || issued_d < 4); k++) begin
            do_i = imem_ready && (issued_i < 4);
            do_d = dmem_ready && (issued_d < 4);
            if (do_i || do_d) begin
                applyStimulus(do_i, 32'h100 + 32'(4 * issued_i), -1,
                              do_d, 32'h200 + 32'(4 * issued_d), 32'h0, 4'h0, -1);
                if (do_i) issued_i++;
                if (do_d) issued_d++;
            end else begin
                tick();
            end
        end
        waitDrain("contention_drain", 40);
        checkOutput("contention_grants", 32'(bram_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < bram_log.size(); k++) begin
            checkOutput("contention_instr", {31'b0, bram_log[k].instr}, 32'(k % 2));
            checkOutput("contention_cycle", 32'(bram_log[k].cyc), 32'(c0 + 1 + 2 * k));
        end

        $display("[TB] reset mid-access");
        applyStimulus(1'b1, 32'h10, -1, 1'b0, 32'h0, 32'h0, 4'h0, -1);
        tick();
        reset = 1'b0;
        imem_q.delete();
        dmem_q.delete();
        @(negedge clock);
        checkOutput("late_bram_ready_seen", {31'b0, bram_ready}, 32'd1);
        checkQuiet("midreset");
        tick();
        reset = 1'b1;
        tick();
        applyStimulus(1'b0, 32'h0, -1, 1'b1, 32'h4, 32'h0, 4'h0, 2);
        waitDrain("post_reset_drain", 20);

        $display("[TB] same-cycle re-issue");
        applyStimulus(1'b1, 32'h10, 2, 1'b0, 32'h0, 32'h0, 4'h0, -1);
        for (int k = 0; k < 10 && !imem_ready; k++) tick();
        checkOutput("reissue_ready_seen", {31'b0, imem_ready}, 32'd1);
        applyStimulus(1'b1, 32'h0, 2, 1'b0, 32'h0, 32'h0, 4'h0, -1);
        waitDrain("reissue_drain", 20);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-port front end for the single-port block RAM: accepts independent instruction-fetch and data requests, buffers one outstanding request per port, arbitrates round-robin, and drives the RAM's single request/response channel. Sits directly upstream of the RAM, between the core's fetch/load-store units and the RAM. It steers the RAM's one-cycle-later ready/rdata back to the granted port.

## Interface
- bram_depth, from configure package: RAM word-address width. The arbiter passes full 32-bit addresses through unmodified.
- reset  in  1  asynchronous, active-low (0 = reset)
- clock  in  1  single clock, rising edge
- imem_valid  in  1  fetch request pulse
- imem_addr  in  32  fetch byte address
- imem_rdata  out  32  fetch data
- imem_ready  out  1  fetch completion pulse
- dmem_valid  in  1  data request pulse
- dmem_addr  in  32  data byte address
- dmem_wdata  in  32  store data
- dmem_wstrb  in  4  byte strobes; 0 = load
- dmem_rdata  out  32  load data
- dmem_ready  out  1  data completion pulse
- bram_valid  out  1  RAM request, one-cycle pulse
- bram_instr  out  1  1 = current access is a fetch
- bram_addr  out  32  RAM address
- bram_wdata  out  32  RAM write data
- bram_wstrb  out  4  RAM strobes; forced 0 on fetch
- bram_rdata  in  32  RAM read data, valid when bram_ready = 1
- bram_ready  in  1  RAM completion, one cycle after bram_valid

## Operation
- Per-port pending register with fields valid, addr, wdata, wstrb. It is loaded at a clock edge when the port's valid = 1. It is cleared at the edge where that port's ready is given.
- If the clear and a load happen at the same edge, the load wins. This lets a requester issue its next request in the same cycle it sees ready.
- A valid while the port's pending entry is already set is a protocol violation. It is ignored, and the bench asserts on it.
- FSM states:
  - IDLE: if either port is pending, grant it, register the bram_* outputs from its pending entry, set bram_valid = 1, and go to ACCESS.
  - ACCESS: bram_valid = 0 after the first cycle, and bram_addr, bram_wdata, bram_wstrb and bram_instr are held stable. On bram_ready = 1, pulse the granted port's ready and clear its pending entry. If another pending entry exists, issue it at that same edge (stay in ACCESS, bram_valid = 1); otherwise go to IDLE.
- Arbitration: the last_grant bit (0 = imem, 1 = dmem) is updated on every grant.
  - Both pending: grant the port that is not last_grant.
  - One pending: grant it.
- Response steering: imem_rdata = dmem_rdata = bram_rdata (combinational). Only the granted port's ready is pulsed. Store completions also pulse dmem_ready; the rdata value is then don't-care.
- bram_ready arriving in IDLE is ignored.

## Timing
- Reset values: bram_valid = 0, bram_instr = 0, bram_addr = 0, bram_wdata = 0, bram_wstrb = 0, imem_ready = 0, dmem_ready = 0, both pending entries cleared, state IDLE, last_grant = 0.
- Reset mid-access abandons the access. A late bram_ready after reset is ignored, and no ready pulse is generated.
- Latency for an uncontended request:
  - valid in cycle N
  - bram_valid in N+1
  - bram_ready and port ready in N+2
- Throughput: one RAM access per 2 cycles. For back-to-back grants, bram_valid for the second access is asserted in the cycle after the first bram_ready.
- Port ready is combinational from bram_ready and the grant. The bram_* outputs are registered.

## Structure
- configure package additions:
  - bram_req_t packed struct {valid, instr, addr[31:0], wdata[31:0], wstrb[3:0]}
  - bram_arb_state_t enum {IDLE, ACCESS}
- One sub-module, bram_pending: a single-entry request register with load/clear and load-wins priority. It is instantiated once per port.

## Test plan
- Single fetch: imem_valid at cycle 1 with addr 0x00000010 and RAM word 4 = 0xDEADBEEF -> bram_valid at cycle 2 with bram_instr = 1 and bram_wstrb = 0; imem_ready = 1 and imem_rdata = 0xDEADBEEF at cycle 3.
- Simultaneous requests after reset: imem to 0x0, dmem load from 0x4 -> dmem is granted first (last_grant = 0) with ready at cycle 3; imem gets ready at cycle 5.
- Store then load: dmem writes 0x11223344 to 0x8 with wstrb = 0101, then loads 0x8 from the original 0xAAAAAAAA -> load returns 0xAA22AA44.
- Continuous contention: both ports re-issue in the same cycle as each ready for 8 requests -> grants strictly alternate, 4 each; the bram_valid pulses are 2 cycles apart.
- Reset mid-access: reset low in the cycle after bram_valid -> no imem_ready or dmem_ready pulse; all outputs return to 0; the next request completes with nominal latency.
- Same-cycle re-issue: imem_valid in the cycle imem_ready = 1 -> the new request is retained and served; no request is lost.
